// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, FSM state encoding and the register-zero index
// for the register file access controller.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int REG_ZERO   = 0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        PRESENT
    } state_e;

endpackage

// File: rtl/regfile_fwd_unit.sv
// regfile_fwd_unit: per-operand writeback forwarding; remembers a write that
// lands on the edge the file samples the address and bypasses a write on the capture edge.
module regfile_fwd_unit #(
    parameter int DATA_W = regfile_pkg::DEF_DATA_W,
    parameter int ADDR_W = regfile_pkg::DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_track,
    input  logic [ADDR_W-1:0] i_rs,
    input  logic              i_wb_fire,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic [DATA_W-1:0] i_rf_rdata,
    output logic [DATA_W-1:0] o_data
);

    logic              r_hit;
    logic [DATA_W-1:0] r_data;
    logic              w_match;

    assign w_match = i_wb_fire && (i_wb_addr == i_rs);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hit  <= 1'b0;
            r_data <= '0;
        end else if (i_track) begin
            r_hit  <= w_match;
            r_data <= i_wb_data;
        end
    end

    // A write on the capture edge is newer than anything remembered from the issue edge.
    assign o_data = w_match ? i_wb_data : r_hit ? r_data : i_rf_rdata;

endmodule

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: operand-fetch sequencer for a synchronous-read register file.
// Define R0_HARDWIRE_EN to make register 0 read as zero and ignore writes to it.
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs1,
    input  logic [ADDR_W-1:0] req_rs2,
    input  logic [ADDR_W-1:0] req_rd,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [ADDR_W-1:0] op_rd,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    state_e            r_state;
    state_e            w_next;
    logic [ADDR_W-1:0] r_rs1;
    logic [ADDR_W-1:0] r_rs2;
    logic              w_accept;
    logic [DATA_W-1:0] w_fa;
    logic [DATA_W-1:0] w_fb;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;

    assign req_ready = rst_n && (r_state == IDLE);
    assign op_valid  = (r_state == PRESENT);
    assign w_accept  = req_valid && req_ready;
    assign wb_ready  = rst_n;
    assign rf_waddr  = wb_addr;
    assign rf_wdata  = wb_data;
    assign rf_raddr1 = r_rs1;
    assign rf_raddr2 = r_rs2;

`ifdef R0_HARDWIRE_EN
    assign rf_we = wb_valid && wb_ready && (wb_addr != ADDR_W'(REG_ZERO));
    assign w_a   = (r_rs1 == ADDR_W'(REG_ZERO)) ? '0 : w_fa;
    assign w_b   = (r_rs2 == ADDR_W'(REG_ZERO)) ? '0 : w_fb;
`else
    assign rf_we = wb_valid && wb_ready;
    assign w_a   = w_fa;
    assign w_b   = w_fb;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? ISSUE : IDLE;
            ISSUE:   w_next = CAPTURE;
            CAPTURE: w_next = PRESENT;
            PRESENT: w_next = op_ready ? IDLE : PRESENT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rs1 <= '0;
            r_rs2 <= '0;
            op_rd <= '0;
            op_a  <= '0;
            op_b  <= '0;
        end else begin
            if (w_accept) begin
                r_rs1 <= req_rs1;
                r_rs2 <= req_rs2;
                op_rd <= req_rd;
            end
            if (r_state == CAPTURE) begin
                op_a <= w_a;
                op_b <= w_b;
            end
        end
    end

    regfile_fwd_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_track    (r_state == ISSUE),
        .i_rs       (r_rs1),
        .i_wb_fire  (rf_we),
        .i_wb_addr  (wb_addr),
        .i_wb_data  (wb_data),
        .i_rf_rdata (rf_rdata1),
        .o_data     (w_fa)
    );

    regfile_fwd_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_track    (r_state == ISSUE),
        .i_rs       (r_rs2),
        .i_wb_fire  (rf_we),
        .i_wb_addr  (wb_addr),
        .i_wb_data  (wb_data),
        .i_rf_rdata (rf_rdata2),
        .o_data     (w_fb)
    );

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: directed and randomized checks of regfile_access_ctrl
// against an architectural register model; honours R0_HARDWIRE_EN.
module tb_regfile_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, op_valid, op_ready, wb_valid, wb_ready, rf_we;
    logic [4:0]  req_rs1, req_rs2, req_rd, op_rd, wb_addr, rf_raddr1, rf_raddr2, rf_waddr;
    logic [31:0] op_a, op_b, wb_data, rf_rdata1, rf_rdata2, rf_wdata;

    int total = 0;
    int bad   = 0;

    regfile_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_rd(op_rd),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    // Register file: synchronous read returning the old value on a same-edge write.
    logic [31:0] mem [32];
    always @(posedge clk) begin
        rf_rdata1 <= mem[rf_raddr1];
        rf_rdata2 <= mem[rf_raddr2];
        if (rf_we) mem[rf_waddr] <= rf_wdata;
    end

    // Architectural model: operands equal the register contents as they stand
    // after the write on the second edge after acceptance.
    logic [31:0] gold [32];
    logic        exp_we;
    logic        m_busy;
    int          m_age;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_a, m_b;

`ifdef R0_HARDWIRE_EN
    assign exp_we = rst_n && wb_valid && (wb_addr != 5'd0);
`else
    assign exp_we = rst_n && wb_valid;
`endif

    function automatic logic [31:0] opval(input logic [4:0] rs);
`ifdef R0_HARDWIRE_EN
        if (rs == 5'd0) return 32'd0;
`endif
        return (exp_we && wb_addr == rs) ? wb_data : gold[rs];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_age  <= 0;
            m_rs1  <= '0;
            m_rs2  <= '0;
            m_rd   <= '0;
            m_a    <= '0;
            m_b    <= '0;
        end else begin
            if (exp_we) gold[wb_addr] <= wb_data;
            if (!m_busy && req_valid) begin
                m_busy <= 1'b1;
                m_age  <= 0;
                m_rs1  <= req_rs1;
                m_rs2  <= req_rs2;
                m_rd   <= req_rd;
            end else if (m_busy) begin
                if (m_age == 1) begin
                    m_a <= opval(m_rs1);
                    m_b <= opval(m_rs2);
                end
                if (m_age < 2) m_age <= m_age + 1;
                else if (op_ready) m_busy <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic compare();
        check("req_ready", 32'(req_ready), 32'(rst_n && !m_busy));
        check("op_valid", 32'(op_valid), 32'(m_busy && m_age >= 2));
        check("wb_ready", 32'(wb_ready), 32'(rst_n));
        check("rf_we", 32'(rf_we), 32'(exp_we));
        check("rf_waddr", 32'(rf_waddr), 32'(wb_addr));
        check("rf_wdata", rf_wdata, wb_data);
        check("rf_raddr1", 32'(rf_raddr1), 32'(m_rs1));
        check("rf_raddr2", 32'(rf_raddr2), 32'(m_rs2));
        check("op_a", op_a, m_a);
        check("op_b", op_b, m_b);
        check("op_rd", 32'(op_rd), 32'(m_rd));
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        req_valid = 1'b1;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_rd    = rd;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
    endtask

    task automatic release_op();
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_rs1   = 5'd0;
        req_rs2   = 5'd0;
        req_rd    = 5'd0;
        op_ready  = 1'b0;
        wb(5'd3, 32'hDEAD);
        @(posedge clk);
        #1;
        tick();
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rf_we", 32'(rf_we), 32'd0);
        rst_n     = 1'b1;
        req_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            wb(5'(i), 32'(i));
            tick();
        end
        wb_valid = 1'b0;

        accept(5'd3, 5'd5, 5'd7);
        tick();
        check("plain_lat", 32'(op_valid), 32'd0);
        tick();
        check("plain_valid", 32'(op_valid), 32'd1);
        check("plain_a", op_a, 32'd3);
        check("plain_b", op_b, 32'd5);
        check("plain_rd", 32'(op_rd), 32'd7);
        repeat (5) tick();
        check("bp_valid", 32'(op_valid), 32'd1);
        check("bp_a", op_a, 32'd3);
        check("bp_req_ready", 32'(req_ready), 32'd0);
        release_op();
        check("bp_after", 32'(req_ready), 32'd1);

        accept(5'd3, 5'd5, 5'd1);
        wb(5'd3, 32'hAAAA);
        tick();
        wb_valid = 1'b0;
        tick();
        check("fwd_e1", op_a, 32'hAAAA);
        release_op();

        accept(5'd3, 5'd5, 5'd2);
        wb(5'd3, 32'hAAAA);
        tick();
        wb(5'd3, 32'hBBBB);
        tick();
        wb_valid = 1'b0;
        check("fwd_e2_wins", op_a, 32'hBBBB);
        release_op();
        accept(5'd3, 5'd3, 5'd2);
        repeat (2) tick();
        check("file_bbbb_a", op_a, 32'hBBBB);
        check("file_bbbb_b", op_b, 32'hBBBB);
        release_op();

        accept(5'd3, 5'd5, 5'd4);
        repeat (2) tick();
        wb(5'd5, 32'h1234);
        tick();
        wb_valid = 1'b0;
        check("late_wb_b", op_b, 32'd5);
        release_op();
        accept(5'd5, 5'd5, 5'd4);
        repeat (2) tick();
        check("late_wb_next", op_a, 32'h1234);
        release_op();

        accept(5'd1, 5'd2, 5'd3);
        tick();
        rst_n = 1'b0;
        wb(5'd6, 32'h77);
        tick();
        check("midrst_valid", 32'(op_valid), 32'd0);
        check("midrst_a", op_a, 32'd0);
        check("midrst_rd", 32'(op_rd), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_rf_we", 32'(rf_we), 32'd0);
        tick();
        rst_n    = 1'b1;
        wb_valid = 1'b0;
        #1;
        check("midrst_release", 32'(req_ready), 32'd1);

        wb(5'd0, 32'hFFFF);
        tick();
        wb_valid = 1'b0;
        accept(5'd0, 5'd6, 5'd0);
        repeat (2) tick();
`ifdef R0_HARDWIRE_EN
        check("r0_a", op_a, 32'd0);
`else
        check("r0_a", op_a, 32'hFFFF);
`endif
        check("r6_untouched", op_b, 32'd6);
        release_op();

        for (int n = 0; n < 500; n++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            req_valid = 1'($urandom_range(0, 1));
            req_rs1   = 5'($urandom_range(0, 3));
            req_rs2   = 5'($urandom_range(0, 3));
            req_rd    = 5'($urandom);
            op_ready  = ($urandom_range(0, 2) == 0);
            wb_valid  = 1'($urandom_range(0, 1));
            wb_addr   = 5'($urandom_range(0, 3));
            wb_data   = $urandom;
            tick();
        end
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
